// File: rtl/downsampler_h_1_scheduler_if.sv
// Port bundle between the pixel source, the downsampler scheduler and the convolution.
// Pixel handshake: a pixel transfers on a rising edge where pix_valid_i && pix_ready_o;
// the source holds pix_i stable while pix_valid_i is high and pix_ready_o is low.
interface downsampler_h_1_scheduler_if #(
    parameter int FP_WIDTH = 16
);
    logic [FP_WIDTH-1:0] pix_i;
    logic                pix_valid_i;
    logic                pix_ready_o;
    logic                credit_i;
    logic [FP_WIDTH-1:0] window_o [1][3];
    logic [FP_WIDTH-1:0] kernel_o [1][3];
    logic [15:0]         col_o;
    logic [15:0]         row_o;
    logic                valid_o;
    logic                frame_done_o;
    logic                credit_err_o;
    logic [1:0]          state_dbg_o;
    logic [15:0]         credits_dbg_o;

    modport slave (
        input  pix_i, pix_valid_i, credit_i,
        output pix_ready_o, window_o, kernel_o, col_o, row_o, valid_o,
               frame_done_o, credit_err_o, state_dbg_o, credits_dbg_o
    );

    modport master (
        output pix_i, pix_valid_i, credit_i,
        input  pix_ready_o, window_o, kernel_o, col_o, row_o, valid_o,
               frame_done_o, credit_err_o, state_dbg_o, credits_dbg_o
    );
endinterface

// File: rtl/downsampler_h_1_scheduler.sv
// Scheduler for the horizontal 2:1 fp16 downsampler: builds 1x3 windows on even columns.
// Build option DS_H_SCHED_ZERO_PAD_EN: zero-pad row borders instead of replicating edge pixels.
module downsampler_h_1_scheduler #(
    parameter int FP_WIDTH     = 16,
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int PIPE_CREDITS = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    downsampler_h_1_scheduler_if.slave bus
);
    localparam int COL_W  = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CRED_W = (PIPE_CREDITS > 1) ? $clog2(PIPE_CREDITS + 1) : 1;

    localparam logic [COL_W-1:0]    LAST_COL   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CRED_W-1:0]   CRED_MAX   = CRED_W'(PIPE_CREDITS);
    localparam logic [15:0]         FLUSH_COL  = 16'((IMG_WIDTH - 1) / 2);
    localparam logic [FP_WIDTH-1:0] KHALF      = FP_WIDTH'(16'h3800);
    localparam bit                  ODD_WIDTH  = (IMG_WIDTH % 2) == 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_FEND  = 2'd2
    } state_e;

    state_e                        state_q;
    logic [COL_W-1:0]              in_col_q;
    logic [ROW_W-1:0]              in_row_q;
    logic [FP_WIDTH-1:0]           prev1_q;
    logic [FP_WIDTH-1:0]           prev2_q;
    logic [ROW_W-1:0]              flush_row_q;
    logic                          flush_last_q;
    logic [CRED_W-1:0]             credits_q;
    logic [CRED_W-1:0]             credits_d;
    logic                          err_q;
    logic                          valid_q;
    logic                          frame_done_q;
    logic [2:0][FP_WIDTH-1:0]      win_q;
    logic [2:0][FP_WIDTH-1:0]      win_d;
    logic [15:0]                   col_q;
    logic [15:0]                   col_d;
    logic [15:0]                   row_q;
    logic [15:0]                   row_d;

    logic                          cred_zero;
    logic                          cred_full;
    logic                          ready;
    logic                          accept;
    logic                          emit_run;
    logic                          emit_flush;
    logic                          emit;
    logic                          at_last_col;
    logic                          at_last_row;
    logic [FP_WIDTH-1:0]           pad_left;
    logic [FP_WIDTH-1:0]           pad_right;

`ifdef DS_H_SCHED_ZERO_PAD_EN
    assign pad_left  = '0;
    assign pad_right = '0;
`else
    assign pad_left  = bus.pix_i;
    assign pad_right = prev1_q;
`endif

    assign cred_zero   = (credits_q == '0);
    assign cred_full   = (credits_q == CRED_MAX);
    assign at_last_col = (in_col_q == LAST_COL);
    assign at_last_row = (in_row_q == LAST_ROW);

    // Odd columns complete a window, so only they need a free result slot.
    assign ready      = rst_i && (state_q == S_RUN) && (!in_col_q[0] || !cred_zero);
    assign accept     = bus.pix_valid_i && ready;
    assign emit_run   = accept && in_col_q[0];
    assign emit_flush = (state_q == S_FLUSH) && !cred_zero;
    assign emit       = emit_run || emit_flush;

    always_comb begin
        credits_d = credits_q;
        if (emit && !bus.credit_i) begin
            credits_d = credits_q - 1'b1;
        end else if (!emit && bus.credit_i && !cred_full) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_comb begin
        win_d    = '0;
        win_d[0] = prev2_q;
        win_d[1] = prev1_q;
        win_d[2] = (state_q == S_FLUSH) ? pad_right : bus.pix_i;
        col_d    = (state_q == S_FLUSH) ? FLUSH_COL : 16'(in_col_q >> 1);
        row_d    = (state_q == S_FLUSH) ? 16'(flush_row_q) : 16'(in_row_q);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_RUN;
            in_col_q     <= '0;
            in_row_q     <= '0;
            prev1_q      <= '0;
            prev2_q      <= '0;
            flush_row_q  <= '0;
            flush_last_q <= 1'b0;
            credits_q    <= CRED_MAX;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            valid_q      <= emit;
            frame_done_q <= 1'b0;
            credits_q    <= credits_d;
            err_q        <= err_q || (bus.credit_i && cred_full);

            if (emit) begin
                win_q <= win_d;
                col_q <= col_d;
                row_q <= row_d;
            end

            if (accept) begin
                // Column 0 seeds the left border so the first window sees p(-1).
                if (in_col_q == '0) begin
                    prev2_q <= pad_left;
                end else begin
                    prev2_q <= prev1_q;
                end
                prev1_q <= bus.pix_i;
                if (at_last_col) begin
                    in_col_q <= '0;
                    in_row_q <= at_last_row ? '0 : in_row_q + 1'b1;
                end else begin
                    in_col_q <= in_col_q + 1'b1;
                end
            end

            unique case (state_q)
                S_RUN: begin
                    if (accept && at_last_col) begin
                        if (ODD_WIDTH) begin
                            state_q      <= S_FLUSH;
                            flush_row_q  <= in_row_q;
                            flush_last_q <= at_last_row;
                        end else if (at_last_row) begin
                            state_q      <= S_FEND;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!cred_zero) begin
                        state_q      <= flush_last_q ? S_FEND : S_RUN;
                        frame_done_q <= flush_last_q;
                    end
                end
                S_FEND: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign bus.pix_ready_o    = ready;
    assign bus.valid_o        = valid_q;
    assign bus.frame_done_o   = frame_done_q;
    assign bus.credit_err_o   = err_q;
    assign bus.col_o          = col_q;
    assign bus.row_o          = row_q;
    assign bus.window_o[0][0] = win_q[0];
    assign bus.window_o[0][1] = win_q[1];
    assign bus.window_o[0][2] = win_q[2];
    assign bus.kernel_o[0][0] = KHALF;
    assign bus.kernel_o[0][1] = '0;
    assign bus.kernel_o[0][2] = KHALF;
    assign bus.state_dbg_o    = state_q;
    assign bus.credits_dbg_o  = 16'(credits_q);
endmodule
